// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: requester owner encoding and default bus widths.
// Consumers: mem_arbiter, arb_rr2.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DS = 1'b1
    } owner_e;

    // Round-robin pick on contention: the side that did not own the last grant.
    function automatic owner_e rr_pick(input owner_e last_owner);
        return (last_owner == OWN_DS) ? OWN_IF : OWN_DS;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant logic for the fetch (IF) and data/stack (DS) requesters.
// MEM_ARB_DS_PRIORITY_EN: DS wins every contention and the last-owner register is dropped.
module arb_rr2
    import cpu_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_req_if,
    input  logic i_req_ds,
    output logic o_gnt_if,
    output logic o_gnt_ds
);

`ifdef MEM_ARB_DS_PRIORITY_EN

    // The reset term keeps grants off while the block is held in reset.
    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_ds = 1'b0;
        if (i_reset_n) begin
            o_gnt_ds = i_req_ds;
            o_gnt_if = i_req_if & ~i_req_ds;
        end
    end

`else

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_ds = 1'b0;
        if (i_reset_n) begin
            if (i_req_if && i_req_ds) begin
                if (rr_pick(last_q) == OWN_IF) begin
                    o_gnt_if = 1'b1;
                end else begin
                    o_gnt_ds = 1'b1;
                end
            end else begin
                o_gnt_if = i_req_if;
                o_gnt_ds = i_req_ds;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (o_gnt_if) begin
            last_d = OWN_IF;
        end else if (o_gnt_ds) begin
            last_d = OWN_DS;
        end
    end

    // Reset to DS so the first contention after reset goes to the fetch side.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_q <= OWN_DS;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data/stack traffic.
// Contention policy selected by MEM_ARB_DS_PRIORITY_EN (see arb_rr2); default is round-robin.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              i_clock,
    input  logic              i_reset_n,

    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,

    input  logic              i_ds_req,
    input  logic              i_ds_we,
    input  logic [ADDR_W-1:0] i_ds_addr,
    input  logic [DATA_W-1:0] i_ds_wdata,
    output logic              o_ds_gnt,
    output logic              o_ds_rvalid,
    output logic [DATA_W-1:0] o_ds_rdata,

    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    logic   gnt_if;
    logic   gnt_ds;
    logic   rd_issue;
    logic   flight_valid_q;
    owner_e flight_owner_q;

    arb_rr2 u_arb (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_req_if  (i_if_req),
        .i_req_ds  (i_ds_req),
        .o_gnt_if  (gnt_if),
        .o_gnt_ds  (gnt_ds)
    );

    // Memory-side mux; idle cycles park address and data at zero.
    always_comb begin
        o_mem_en    = gnt_if | gnt_ds;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (gnt_ds) begin
            o_mem_we    = i_ds_we;
            o_mem_addr  = i_ds_addr;
            o_mem_wdata = i_ds_wdata;
        end else if (gnt_if) begin
            o_mem_addr  = i_if_addr;
        end
    end

    assign o_if_gnt = gnt_if;
    assign o_ds_gnt = gnt_ds;
    assign rd_issue = o_mem_en & ~o_mem_we;

    // One entry is enough: memory read latency is exactly one cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            flight_valid_q <= 1'b0;
            flight_owner_q <= OWN_IF;
        end else begin
            flight_valid_q <= rd_issue;
            flight_owner_q <= gnt_ds ? OWN_DS : OWN_IF;
        end
    end

    always_comb begin
        o_if_rvalid = flight_valid_q & (flight_owner_q == OWN_IF);
        o_ds_rvalid = flight_valid_q & (flight_owner_q == OWN_DS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ds_rdata  = o_ds_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of both requesters and the memory port, the SHALL be the case for all address ports.
REQ-002 Parameter DATA_W, default 16, data width of all data ports.
REQ-003 i_clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_if_req  input  1  instruction-fetch request, held high until granted.
REQ-006 i_if_addr  input  ADDR_W  fetch address (the IP value).
REQ-007 o_if_gnt  output  1  fetch request accepted this cycle.
REQ-008 o_if_rvalid  output  1  o_if_rdata valid this cycle.
REQ-009 o_if_rdata  output  DATA_W  fetched instruction word.
REQ-010 i_ds_req  input  1  data/stack-spill request, held high until granted.
REQ-011 i_ds_we  input  1  1 = write, 0 = read.
REQ-012 i_ds_addr  input  ADDR_W  data address (SP-derived).
REQ-013 i_ds_wdata  input  DATA_W  write data (spilled T/stack word).
REQ-014 o_ds_gnt, o_ds_rvalid  output  1 each  data accept / read-data valid.
REQ-015 o_ds_rdata  output  DATA_W  read data.
REQ-016 o_mem_en, o_mem_we  output  1 each  memory access strobe / write enable.
REQ-017 o_mem_addr, o_mem_wdata  output  ADDR_W, DATA_W  memory address / write data.
REQ-018 i_mem_rdata  input  DATA_W  synchronous-read memory data, valid one cycle after o_mem_en with o_mem_we=0.

Function
REQ-019 Grant decision SHALL be combinational in cycle N: o_*_gnt, o_mem_en and memory address/data mux all in the same cycle as the winning request.
REQ-020 At most one of o_if_gnt, o_ds_gnt SHALL be high in any cycle; o_mem_en = o_if_gnt | o_ds_gnt.
REQ-021 Only one requester high: it SHALL be granted immediately.
REQ-022 Both high: arbiter SHALL grant the requester not recorded in the last-owner register (round-robin); last-owner updates on every grant.
REQ-023 Fetch accesses SHALL drive o_mem_we=0; data accesses drive o_mem_we=i_ds_we.
REQ-024 A granted read SHALL produce exactly one rvalid pulse on the owning port in cycle N+1, with rdata = i_mem_rdata; the other port's rvalid stays 0.
REQ-025 Granted writes SHALL produce no rvalid.
REQ-026 Back-to-back grants every cycle SHALL be supported; pipeline register holds {valid, owner} of the access in flight.
REQ-027 o_*_rdata SHALL be 0 when the corresponding rvalid is 0.
REQ-028 No requester SHALL wait more than one cycle under continuous contention (round-robin mode).

Reset
REQ-029 On i_reset_n low, asynchronously: all gnt/rvalid/mem_en/mem_we low, addr/wdata/rdata 0, in-flight valid 0, last-owner = DS (first contention grants IF).
REQ-030 Reset mid-read SHALL discard the in-flight access; no rvalid after release.
REQ-031 First grant possible in the first rising edge cycle after reset release.

Configuration
REQ-032 Macro MEM_ARB_DS_PRIORITY_EN: defined -> data port has fixed priority on contention, last-owner register unused; undefined -> round-robin per REQ-022.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the owner encoding (OWN_IF=0, OWN_DS=1) and default ADDR_W/DATA_W constants.
REQ-034 Sub-module arb_rr2 (two-way round-robin grant logic with last-owner register) SHALL be instantiated; response pipeline stays in mem_arbiter.

Verification
REQ-035 IF only, addr 0x0000, mem returns 0x1234 -> o_if_gnt in N, o_if_rvalid=1 with 0x1234 in N+1, o_ds_rvalid=0.
REQ-036 Both req after reset (IF 0x0010, DS read 0x8000) -> IF granted N, DS granted N+1, responses N+1 (IF) and N+2 (DS).
REQ-037 Continuous both req 6 cycles -> grants alternate IF,DS,IF,DS,IF,DS; never both high.
REQ-038 DS write 0xBEEF to 0x7FFE -> o_mem_we=1, addr 0x7FFE, wdata 0xBEEF in N; no rvalid in N+1.
REQ-039 Reset asserted in cycle after a DS read grant -> no o_ds_rvalid; all outputs 0.
REQ-040 With MEM_ARB_DS_PRIORITY_EN, both req continuous 4 cycles -> DS granted all 4, IF never.
